// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures pulse high time and rising-edge period
// in prescaled ticks and exposes the results on an Avalon-MM slave.
`timescale 1ns/1ps
module servo_pwm_capture #(
  parameter int TICK_DIV = 50,
  parameter int TIMEOUT  = 50000
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  input  logic        pwm_in
);

  localparam logic [31:0] ID = 32'hEA680013;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  // a full-scale TIMEOUT can never be told apart from counter saturation,
  // so it disables the timeout instead
  localparam bit TMO_EN = (TIMEOUT < 65535);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_RISE, S_HIGH, S_LOW
  } state_t;

  state_t      state;
  logic        enable;
  logic        sync0, sync1, prev;
  logic [PW-1:0] presc;
  logic        tick;
  logic        have_rise;
  logic [15:0] width_cnt, per_cnt;
  logic [15:0] width_r, period_r, count_r;
  logic        st_valid, st_tmo, st_ovf, st_new;
  logic        ctrl_wr, clr, en_nxt, rd_width;
  logic        rise, fall, tmo_hit;
  logic        width_sat, per_sat;
  logic [15:0] w_next, p_next;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign avs_ctrl_waitrequest = 1'b0;
  assign unused_bits = ^{avs_ctrl_writedata[31:2],
                         avs_ctrl_byteenable[3:1]};

  assign ctrl_wr  = avs_ctrl_write && (avs_ctrl_address == 3'd1)
                    && avs_ctrl_byteenable[0];
  assign clr      = ctrl_wr && avs_ctrl_writedata[1];
  assign en_nxt   = ctrl_wr ? avs_ctrl_writedata[0] : enable;
  assign rd_width = avs_ctrl_read && (avs_ctrl_address == 3'd3);

  assign rise      = sync1 & ~prev;
  assign fall      = ~sync1 & prev;
  assign tick      = enable && (presc == PMAX);
  assign tmo_hit   = TMO_EN && (per_cnt == TMO);
  assign width_sat = (width_cnt == 16'hFFFF);
  assign per_sat   = (per_cnt == 16'hFFFF);
  assign w_next    = width_sat ? width_cnt : width_cnt + 16'd1;
  assign p_next    = per_sat ? per_cnt : per_cnt + 16'd1;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      enable <= 1'b0;
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      prev   <= 1'b0;
      presc  <= '0;
    end else begin
      if (ctrl_wr) enable <= avs_ctrl_writedata[0];
      sync0 <= pwm_in;
      sync1 <= sync0;
      prev  <= sync1;
      if (!enable || presc == PMAX) presc <= '0;
      else presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state     <= S_IDLE;
      have_rise <= 1'b0;
      width_cnt <= '0;
      per_cnt   <= '0;
      width_r   <= '0;
      period_r  <= '0;
      count_r   <= '0;
      st_valid  <= 1'b0;
      st_tmo    <= 1'b0;
      st_ovf    <= 1'b0;
      st_new    <= 1'b0;
    end else begin
      if (rd_width) st_new <= 1'b0;
      if (clr) begin
        state     <= en_nxt ? S_ARM : S_IDLE;
        have_rise <= 1'b0;
        width_cnt <= '0;
        per_cnt   <= '0;
        width_r   <= '0;
        period_r  <= '0;
        count_r   <= '0;
        st_valid  <= 1'b0;
        st_tmo    <= 1'b0;
        st_ovf    <= 1'b0;
        st_new    <= 1'b0;
      end else if (!enable) begin
        state     <= S_IDLE;
        have_rise <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: state <= S_ARM;
          S_ARM: begin
            have_rise <= 1'b0;
            width_cnt <= '0;
            per_cnt   <= '0;
            if (!sync1) state <= S_WAIT_RISE;
          end
          S_WAIT_RISE, S_HIGH, S_LOW: begin
            if (tmo_hit) begin
              st_tmo    <= 1'b1;
              st_valid  <= 1'b0;
              have_rise <= 1'b0;
              state     <= S_ARM;
            end else if (state == S_WAIT_RISE) begin
              if (tick) per_cnt <= p_next;
              if (rise) begin
                width_cnt <= '0;
                per_cnt   <= '0;
                have_rise <= 1'b1;
                state     <= S_HIGH;
              end
            end else if (state == S_HIGH) begin
              if (tick) begin
                width_cnt <= w_next;
                per_cnt   <= p_next;
              end
              if (width_sat) st_ovf <= 1'b1;
              if (fall) begin
                width_r  <= width_cnt;
                st_valid <= 1'b1;
                st_new   <= 1'b1;
                st_tmo   <= 1'b0;
                count_r  <= count_r + 16'd1;
                state    <= S_LOW;
              end
            end else begin
              if (tick) per_cnt <= p_next;
              if (rise) begin
                if (have_rise) period_r <= per_cnt;
                width_cnt <= '0;
                per_cnt   <= '0;
                state     <= S_HIGH;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_ctrl_address)
      3'd0: rd_mux = ID;
      3'd1: rd_mux = {31'b0, enable};
      3'd2: rd_mux = {28'b0, st_new, st_ovf, st_tmo, st_valid};
      3'd3: rd_mux = {16'b0, width_r};
      3'd4: rd_mux = {16'b0, period_r};
      3'd5: rd_mux = {16'b0, count_r};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) avs_ctrl_readdata <= '0;
    else if (avs_ctrl_read) avs_ctrl_readdata <= rd_mux;
  end

endmodule

// File: doc/servo_pwm_capture.md
# servo_pwm_capture

Servo-PWM capture block: measures the high time and period of an incoming RC/servo pulse train (e.g. from an RC receiver channel) and exposes the results on a Qsys Avalon-MM slave. It is the receive-side counterpart of the steering/servo PWM generators and sits on the same control bus, on the FPGA input pin side. All timing is expressed in prescaled ticks, 1 µs each by default.

## Interface
- TICK_DIV, 50: clock cycles per measurement tick (50 MHz → 1 µs).
- TIMEOUT, 50000: ticks without a valid edge before the signal is declared lost.
- csi_MCLK_clk  in  1  sole clock; bus, synchronizer and counters.
- rsi_MRST_reset  in  1  asynchronous, active-high reset.
- avs_ctrl_address  in  3  word address.
- avs_ctrl_write / avs_ctrl_read  in  1  Avalon strobes.
- avs_ctrl_writedata  in  32  write data.
- avs_ctrl_byteenable  in  4  byte lanes; only lane 0 is used (CTRL).
- avs_ctrl_readdata  out  32  registered read data.
- avs_ctrl_waitrequest  out  1  tied 0.
- pwm_in  in  1  asynchronous servo pulse input.

## Operation
- Register map:
  - 0: ID = 0xEA680013 (RO).
  - 1: CTRL, bit0 ENABLE (RW), bit1 CLEAR (write-1, self-clearing, reads 0).
  - 2: STATUS (RO), bit0 VALID, bit1 TIMEOUT, bit2 OVF, bit3 NEW.
  - 3: WIDTH[15:0] (RO); reading it clears NEW.
  - 4: PERIOD[15:0] (RO), rising-to-rising.
  - 5: COUNT[15:0] (RO), captured pulses, wraps 0xFFFF→0.
  - 6–7: read 0, writes ignored.
- pwm_in passes through a 2-FF synchronizer and then an edge detector (prev-sample register).
- The tick prescaler counts 0..TICK_DIV-1 while ENABLE=1 and holds at 0 otherwise.
- Width and period counters are 16 bits, increment on ticks and saturate at 0xFFFF. Saturation of the width counter sets OVF (sticky).
- FSM states: IDLE, ARM, WAIT_RISE, HIGH, LOW.
  - IDLE: ENABLE=0. Only transition is ENABLE=1 → ARM.
  - ARM: discards any partial pulse. Synced input low → WAIT_RISE.
  - WAIT_RISE: rise → HIGH; clear the width and period counters; set have_rise.
  - HIGH: fall → LOW; WIDTH ← width counter; VALID=1, NEW=1, TIMEOUT=0; COUNT+1.
  - LOW: rise → HIGH; PERIOD ← period counter; restart both counters.
  - Timeout: in WAIT_RISE, HIGH or LOW, period counter reaching TIMEOUT → TIMEOUT=1, VALID=0, have_rise=0, go to ARM. WIDTH and PERIOD retain their values.
- PERIOD is latched only on a rise that follows an earlier rise in the same armed session. The first rise after arming never updates PERIOD.
- ENABLE=0 forces IDLE from any state and clears have_rise; all result registers hold.
- CLEAR: WIDTH, PERIOD, COUNT and STATUS are zeroed, and the FSM goes to ARM if enabled or IDLE otherwise. ENABLE is unchanged.

## Timing
- Reset values:
  - readdata=0, waitrequest=0.
  - CTRL=0, STATUS=0, WIDTH=0, PERIOD=0, COUNT=0.
  - FSM=IDLE, prescaler=0.
  - Synchronizer flops=0.
- Read latency is 1 cycle: readdata is valid the cycle after avs_ctrl_read. When read is deasserted, readdata holds its value.
- A write takes effect on the clock edge where avs_ctrl_write=1. The CTRL write requires byteenable[0]=1.
- Pin-to-edge-detect latency is 3 cycles. Captured values are visible to a read issued the cycle after the latching edge.
- Measurement quantization is ±1 tick.
- Capture and read of WIDTH in the same cycle: the read returns the old WIDTH and NEW stays 1 (set wins over clear).
- Capture and CLEAR in the same cycle: CLEAR wins.
- A reset mid-pulse aborts immediately. After ENABLE is set, the block passes through ARM, so the first WIDTH reported is from a complete pulse.

## Test plan
- Reset, then read addr 0 and addr 1 → 0xEA680013, then 0; readdata updates 1 cycle after read.
- ENABLE=1; drive 1500 µs high / 20000 µs period for 3 pulses (50 MHz clock, defaults) → WIDTH=1500±1, PERIOD=20000±1 after the 2nd rise, COUNT=3, STATUS=0x9; reading WIDTH clears NEW (STATUS=0x1).
- Enable while pwm_in is already high mid-pulse → the partial pulse is ignored; the first WIDTH equals the next full pulse; PERIOD is still 0 after the first capture.
- Valid train, then hold pwm_in low for 50 ms → TIMEOUT=1, VALID=0, WIDTH retains 1500; a restarted train recovers with VALID=1, TIMEOUT=0.
- Hold pwm_in high for >65.535 ms with TIMEOUT overridden to 0xFFFF → OVF=1 and WIDTH saturates at 0xFFFF when the pulse falls; then CLEAR → all of addr 2..5 read 0.
- Assert rsi_MRST_reset mid-HIGH → all registers return to 0 and the FSM returns to IDLE; captures resume only after ENABLE is rewritten.
